// File: rtl/bcd_rtc_pkg.sv
// Shared BCD types, constants and hour-format conversion helpers for the RTC.
package bcd_rtc_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  typedef struct packed {
    logic      pm;
    bcd_pair_t hh;
  } hour12_t;

  localparam bcd_pair_t BCD_00 = 8'h00;
  localparam bcd_pair_t BCD_12 = 8'h12;
  localparam bcd_pair_t BCD_23 = 8'h23;
  localparam bcd_pair_t BCD_59 = 8'h59;

  function automatic logic bcd_valid(input bcd_pair_t v, input bcd_pair_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic [6:0] bcd2bin(input bcd_pair_t v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic bcd_pair_t bin2bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic bcd_pair_t to24(input bcd_pair_t h, input logic pm);
    logic [6:0] b;
    b = bcd2bin(h);
    if (b == 7'd12) return pm ? BCD_12 : BCD_00;
    return pm ? bin2bcd(b + 7'd12) : h;
  endfunction

  function automatic hour12_t to12(input bcd_pair_t h);
    hour12_t    r;
    logic [6:0] b;
    b    = bcd2bin(h);
    r.pm = (b >= 7'd12);
    if (b == 7'd0)       r.hh = BCD_12;
    else if (b > 7'd12)  r.hh = bin2bcd(b - 7'd12);
    else                 r.hh = h;
    return r;
  endfunction

endpackage

// File: rtl/bcd_rtc_alarm_counter.sv
// Two-digit BCD counter wrapping at MAX, with carry-out and synchronous load.
module bcd_mod_counter
  import bcd_rtc_pkg::*;
#(
  parameter bcd_pair_t MAX = BCD_59
) (
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      inc_i,
  input  logic      ld_i,
  input  bcd_pair_t ld_val_i,
  output bcd_pair_t q_o,
  output logic      carry_o
);

  bcd_pair_t cnt_q, cnt_d;

  assign q_o     = cnt_q;
  assign carry_o = inc_i && (cnt_q == MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)       cnt_d = ld_val_i;
    else if (inc_i) cnt_d = (cnt_q == MAX) ? BCD_00 : bcd_inc(cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) cnt_q <= BCD_00;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_rtc_alarm.sv
// BCD real-time clock with 12/24-hour display, validated loads and an hh:mm alarm.
module bcd_rtc_alarm
  import bcd_rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 1,
  parameter bit          ALARM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       mode24,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  input  logic       ld_pm,
  input  logic       alm_set,
  input  logic [7:0] alm_hh,
  input  logic [7:0] alm_mm,
  input  logic       alm_pm,
  input  logic       alm_en,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       tick,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned   PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] div_q, div_d;
  bcd_pair_t     hh_q, hh_d;
  logic          pm_q, pm_d, mode_q, mode_d, tick_q, err_q;
  logic          tick_now, adv, ld_ok, alm_ok, ld_wr;
  logic          ss_carry, mm_carry;
  bcd_pair_t     cur24, nxt24, mm_nxt;
  hour12_t       h12;

  function automatic logic hour_ok(input bcd_pair_t h, input logic m24);
    return m24 ? bcd_valid(h, BCD_23) : (bcd_valid(h, BCD_12) && (h != BCD_00));
  endfunction

  assign ld_ok    = hour_ok(ld_hh, mode24) && bcd_valid(ld_mm, BCD_59) && bcd_valid(ld_ss, BCD_59);
  assign alm_ok   = hour_ok(alm_hh, mode24) && bcd_valid(alm_mm, BCD_59);
  assign ld_wr    = load && ld_ok;
  assign tick_now = ena && (div_q == DIV_LAST);
  // Any load request, even a rejected one, swallows a coincident tick.
  assign adv      = tick_now && !load;

  bcd_mod_counter #(.MAX(BCD_59)) u_ss (
    .clk_i(clk), .reset_n_i(reset_n), .inc_i(adv), .ld_i(ld_wr),
    .ld_val_i(ld_ss), .q_o(ss), .carry_o(ss_carry)
  );

  bcd_mod_counter #(.MAX(BCD_59)) u_mm (
    .clk_i(clk), .reset_n_i(reset_n), .inc_i(ss_carry), .ld_i(ld_wr),
    .ld_val_i(ld_mm), .q_o(mm), .carry_o(mm_carry)
  );

  always_comb begin
    div_d = div_q;
    if (ld_wr)      div_d = '0;
    else if (load)  div_d = div_q;
    else if (ena)   div_d = tick_now ? '0 : div_q + PW'(1);
  end

  // Hours are advanced in 24-hour form, so a mode change and a tick on the
  // same edge compose naturally: convert first, then increment.
  always_comb begin
    cur24  = mode_q ? hh_q : to24(hh_q, pm_q);
    nxt24  = (adv && mm_carry) ? ((cur24 == BCD_23) ? BCD_00 : bcd_inc(cur24)) : cur24;
    mm_nxt = mm_carry ? BCD_00 : bcd_inc(mm);
    h12    = to12(nxt24);
    hh_d   = hh_q;
    pm_d   = pm_q;
    mode_d = mode_q;
    if (ld_wr) begin
      hh_d   = ld_hh;
      pm_d   = mode24 ? (ld_hh >= BCD_12) : ld_pm;
      mode_d = mode24;
    end else if (!load) begin
      hh_d   = mode24 ? nxt24 : h12.hh;
      pm_d   = h12.pm;
      mode_d = mode24;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q  <= '0;
      hh_q   <= mode24 ? BCD_00 : BCD_12;
      pm_q   <= 1'b0;
      mode_q <= mode24;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      hh_q   <= hh_d;
      pm_q   <= pm_d;
      mode_q <= mode_d;
      tick_q <= adv;
      err_q  <= (load && !ld_ok) || (alm_set && !alm_ok);
    end
  end

  assign hh       = hh_q;
  assign pm       = pm_q;
  assign tick     = tick_q;
  assign load_err = err_q;

  generate
    if (ALARM_EN) begin : g_alarm
      bcd_pair_t alm_h_q, alm_m_q;
      logic      alarm_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          alm_h_q <= BCD_00;
          alm_m_q <= BCD_00;
          alarm_q <= 1'b0;
        end else begin
          if (alm_set && alm_ok) begin
            alm_h_q <= mode24 ? alm_hh : to24(alm_hh, alm_pm);
            alm_m_q <= alm_mm;
          end
          alarm_q <= alm_en && adv && ss_carry && (mm_nxt == alm_m_q) && (nxt24 == alm_h_q);
        end
      end

      assign alarm = alarm_q;
    end else begin : g_no_alarm
      assign alarm = 1'b0;
    end
  endgenerate

endmodule
